audio_frame_scheduler: RTL and testbench
========================================

Name: audio_frame_scheduler

Overview:
Single-clock sequencer for the audio datapath: ADC (SPI) capture, then signal processing, then I2S transmit. Runs on the 12.288 MHz master clock and derives the 3.072 MHz serial clock, word select and bit counter from one frame counter. Once per 48 kHz frame it requests one ADC sample, hands it to the DSP, and loads the DSP result into the I2S transmitter at a fixed slot boundary. It detects and counts deadline misses (underruns).

Parameters:
SAMPLE_W, 16, sample width on ADC, DSP and transmit paths
MCLK_PER_BCLK, 4, input_clk cycles per serial_clk period (power of 2)
BITS_PER_SLOT, 32, serial_clk periods per word-select half
UNDERRUN_W, 8, width of saturating underrun counter

Ports:
input_clk  in  1  master clock, 12.288 MHz
reset  in  1  synchronous, active-high
enable  in  1  run request; sampled every cycle
serial_clk  out  1  derived bit clock, registered
ws  out  1  word select: 0 = left slot, 1 = right slot
bit_counter  out  5  bit index within the current slot
frame_start  out  1  one-cycle pulse at frame position 0
adc_req  out  1  ADC sample request, level
adc_ack  in  1  ADC sample valid; adc_data is captured when ack=1 and req=1
adc_data  in  SAMPLE_W  ADC sample
dsp_in_valid  out  1  one-cycle pulse
dsp_in_data  out  SAMPLE_W  sample to DSP
dsp_out_valid  in  1  DSP result valid, one-cycle pulse
dsp_out_data  in  SAMPLE_W  DSP result
tx_sample  out  SAMPLE_W  word for the I2S transmitter
tx_load  out  1  one-cycle pulse; tx_sample is valid in the same cycle
underrun_count  out  UNDERRUN_W  saturating count of missed deadlines
busy  out  1  high whenever state != IDLE

Behaviour:
- Frame position pos: 0..FRAME_LEN-1, where FRAME_LEN = 2*BITS_PER_SLOT*MCLK_PER_BCLK = 256 with defaults. pos wraps from 255 to 0.
- All outputs are registered.
- Reset, and the IDLE state: pos=0, serial_clk=0, ws=0, bit_counter=0, frame_start=0, adc_req=0, dsp_in_valid=0, dsp_in_data=0, tx_sample=0, tx_load=0, underrun_count=0, busy=0, pending_valid=0.
- Clock derivation, with defaults:
  - serial_clk=pos[1], giving high for the 2 cycles of pos mod 4 in {2,3}.
  - bit_counter=pos[6:2].
  - ws=pos[7].
- FSM states: IDLE, ACQUIRE, PROCESS, WAIT_SLOT.
- IDLE: pos is held at 0. When enable=1, the next cycle enters ACQUIRE with pos=0, frame_start=1 and adc_req=1.
- ACQUIRE: adc_req is held high. On adc_ack=1, capture adc_data, drop adc_req next cycle, go to PROCESS, and pulse dsp_in_valid with dsp_in_data = the captured sample.
- PROCESS: on dsp_out_valid=1, latch dsp_out_data into pending, set pending_valid, and go to WAIT_SLOT. dsp_in_valid is never re-pulsed.
- Deadline at pos=255, evaluated every running frame:
  - If pending_valid was set before this cycle: tx_sample=pending, tx_load=1 for the cycle, clear pending_valid.
  - Otherwise (underrun): tx_sample holds its previous value, tx_load=1, underrun_count+1 saturating at all-ones. Any ACQUIRE/PROCESS work in flight is abandoned: adc_req=0 in this cycle, and a late dsp_out_valid or adc_ack is ignored until the next ACQUIRE.
  - dsp_out_valid arriving exactly at pos=255 counts as late: underrun, and the data is discarded.
- At pos=255 → 0:
  - If enable=1: go to ACQUIRE, pulse frame_start and raise adc_req.
  - If enable=0: go to IDLE. A mid-frame enable drop always completes the current frame, including its tx_load.
- Simultaneous adc_ack and deadline at pos=255: the deadline wins and the ack is ignored.
- Reset asserted mid-frame: all state returns to reset values on the next edge, with no partial tx_load.

Decomposition:
- Package audio_sched_pkg:
  - state_t enum (IDLE, ACQUIRE, PROCESS, WAIT_SLOT)
  - sample_t = logic [SAMPLE_W-1:0]
  - FRAME_LEN, DEADLINE_POS = FRAME_LEN-1
  - default sample rate constants
- Sub-module audio_frame_counter: pos counter with hold/run control, plus derivation of serial_clk, ws, bit_counter and frame_start. Instanced once.
- FSM, pending register and underrun counter stay in the top module.

Test Plan:
- Hold reset 5 cycles with enable=1 → every output equals its reset value; busy=0; pos stays 0.
- Enable with adc_ack never asserted → serial_clk period 4 cycles (high for 2); bit_counter steps 0..31 every 4 cycles; ws rises at pos 128; frame_start every 256 cycles.
- adc_ack 10 cycles after adc_req with adc_data=16'h1234; DSP returns 16'h1235 after 20 cycles → dsp_in_data=16'h1234 pulsed once; tx_sample=16'h1235 with tx_load at pos 255; underrun_count=0.
- Two frames, where the second gets no dsp_out_valid → second tx_load repeats 16'h1235; underrun_count=1; adc_req low at pos 255; a new request at the next pos 0.
- dsp_out_valid exactly at pos 255 with 16'hBEEF → underrun_count increments; tx_sample is not 16'hBEEF; BEEF is never emitted.
- Drop enable at pos 100 → tx_load still at pos 255, then IDLE, busy=0, serial_clk=0. Separately, preset underrun_count=255 and force an underrun → it stays 255.

Source files
------------

// File: rtl/audio_sched_pkg.sv
// audio_sched_pkg: shared state encoding, sample type and default frame timing for the audio scheduler.
package audio_sched_pkg;
    localparam int DEF_SAMPLE_W      = 16;
    localparam int DEF_MCLK_PER_BCLK = 4;
    localparam int DEF_BITS_PER_SLOT = 32;
    localparam int DEF_UNDERRUN_W    = 8;
    localparam int FRAME_LEN         = 2 * DEF_BITS_PER_SLOT * DEF_MCLK_PER_BCLK;
    localparam int DEADLINE_POS      = FRAME_LEN - 1;
    localparam int MCLK_HZ           = 12_288_000;
    localparam int BCLK_HZ           = MCLK_HZ / DEF_MCLK_PER_BCLK;
    localparam int FS_HZ             = MCLK_HZ / FRAME_LEN;
    typedef enum logic [1:0] {IDLE, ACQUIRE, PROCESS, WAIT_SLOT} state_t;
    typedef logic [DEF_SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/audio_frame_counter.sv
// audio_frame_counter: frame position counter; derives serial_clk, ws, bit_counter and frame_start.
//   input_clk, reset : master clock, synchronous active-high reset
//   run              : scheduler is out of IDLE (pos advances), else pos held at 0
//   enable           : a new frame starts after IDLE or after the last position
//   pos              : current frame position
//   serial_clk, ws, bit_counter, frame_start : registered timing outputs aligned to pos
module audio_frame_counter #(
    parameter int MCLK_PER_BCLK = 4,
    parameter int BITS_PER_SLOT = 32,
    parameter int POS_W         = $clog2(2 * BITS_PER_SLOT * MCLK_PER_BCLK)
) (
    input  logic                             input_clk,
    input  logic                             reset,
    input  logic                             run,
    input  logic                             enable,
    output logic [POS_W-1:0]                 pos,
    output logic                             serial_clk,
    output logic                             ws,
    output logic [$clog2(BITS_PER_SLOT)-1:0] bit_counter,
    output logic                             frame_start
);
    localparam int CK = $clog2(MCLK_PER_BCLK);
    localparam int BW = $clog2(BITS_PER_SLOT);
    localparam logic [POS_W-1:0] ONE = {{(POS_W-1){1'b0}}, 1'b1};
    logic [POS_W-1:0] pos_next;
    always_comb pos_next = run ? pos + ONE : '0;
    // Timing outputs are registered from pos_next so they line up with pos in the same cycle.
    always_ff @(posedge input_clk) begin
        if (reset) begin
            pos         <= '0;
            serial_clk  <= 1'b0;
            ws          <= 1'b0;
            bit_counter <= '0;
            frame_start <= 1'b0;
        end else begin
            pos         <= pos_next;
            serial_clk  <= pos_next[CK-1];
            ws          <= pos_next[POS_W-1];
            bit_counter <= pos_next[CK +: BW];
            frame_start <= enable && (!run || pos == '1);
        end
    end
endmodule

// File: rtl/audio_frame_scheduler.sv
// audio_frame_scheduler: per-frame ADC -> DSP -> I2S sequencing with deadline (underrun) tracking.
//   input_clk, reset        : master clock, synchronous active-high reset
//   enable                  : run request, checked at every frame boundary
//   serial_clk, ws, bit_counter, frame_start : derived I2S timing
//   adc_req/adc_ack/adc_data               : ADC sample handshake
//   dsp_in_valid/dsp_in_data               : sample handed to the DSP
//   dsp_out_valid/dsp_out_data             : DSP result
//   tx_sample/tx_load                      : word loaded into the transmitter at the last frame position
//   underrun_count                         : saturating count of missed deadlines
//   busy                                   : scheduler is out of IDLE
module audio_frame_scheduler
    import audio_sched_pkg::*;
#(
    parameter int SAMPLE_W      = DEF_SAMPLE_W,
    parameter int MCLK_PER_BCLK = DEF_MCLK_PER_BCLK,
    parameter int BITS_PER_SLOT = DEF_BITS_PER_SLOT,
    parameter int UNDERRUN_W    = DEF_UNDERRUN_W
) (
    input  logic                             input_clk,
    input  logic                             reset,
    input  logic                             enable,
    output logic                             serial_clk,
    output logic                             ws,
    output logic [$clog2(BITS_PER_SLOT)-1:0] bit_counter,
    output logic                             frame_start,
    output logic                             adc_req,
    input  logic                             adc_ack,
    input  logic [SAMPLE_W-1:0]              adc_data,
    output logic                             dsp_in_valid,
    output logic [SAMPLE_W-1:0]              dsp_in_data,
    input  logic                             dsp_out_valid,
    input  logic [SAMPLE_W-1:0]              dsp_out_data,
    output logic [SAMPLE_W-1:0]              tx_sample,
    output logic                             tx_load,
    output logic [UNDERRUN_W-1:0]            underrun_count,
    output logic                             busy
);
    localparam int POS_W = $clog2(2 * BITS_PER_SLOT * MCLK_PER_BCLK);
    localparam logic [POS_W-1:0] NEAR = {{(POS_W-1){1'b1}}, 1'b0};
    localparam logic [UNDERRUN_W-1:0] U_ONE = {{(UNDERRUN_W-1){1'b0}}, 1'b1};
    state_t state, state_next;
    logic [POS_W-1:0] pos;
    logic [SAMPLE_W-1:0] pending, tx_next;
    logic pending_valid, run, near, last, on_time, take_adc, take_dsp, idle_next;
    audio_frame_counter #(
        .MCLK_PER_BCLK(MCLK_PER_BCLK),
        .BITS_PER_SLOT(BITS_PER_SLOT),
        .POS_W        (POS_W)
    ) u_counter (
        .input_clk  (input_clk),
        .reset      (reset),
        .run        (run),
        .enable     (enable),
        .pos        (pos),
        .serial_clk (serial_clk),
        .ws         (ws),
        .bit_counter(bit_counter),
        .frame_start(frame_start)
    );
    // Registered outputs become visible one edge later, so the deadline decisions that must
    // show during the last position are taken on the edge leaving the position before it (near).
    always_comb begin
        run        = state != IDLE;
        near       = run && pos == NEAR;
        last       = run && pos == '1;
        take_adc   = state == ACQUIRE && adc_ack && !near;
        take_dsp   = state == PROCESS && dsp_out_valid && !near;
        on_time    = pending_valid || (state == PROCESS && dsp_out_valid);
        state_next = (!run || last) ? (enable ? ACQUIRE : IDLE) :
                     near ? WAIT_SLOT :
                     take_adc ? PROCESS :
                     take_dsp ? WAIT_SLOT : state;
        idle_next  = state_next == IDLE;
        tx_next    = !near ? tx_sample :
                     pending_valid ? pending :
                     on_time ? dsp_out_data : tx_sample;
    end
    always_ff @(posedge input_clk) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            adc_req        <= 1'b0;
            dsp_in_valid   <= 1'b0;
            dsp_in_data    <= '0;
            pending        <= '0;
            pending_valid  <= 1'b0;
            tx_load        <= 1'b0;
            tx_sample      <= '0;
            underrun_count <= '0;
        end else begin
            state          <= state_next;
            busy           <= !idle_next;
            adc_req        <= state_next == ACQUIRE;
            dsp_in_valid   <= take_adc;
            dsp_in_data    <= idle_next ? '0 : take_adc ? adc_data : dsp_in_data;
            pending        <= take_dsp ? dsp_out_data : pending;
            pending_valid  <= !idle_next && !near && (take_dsp || pending_valid);
            tx_load        <= near;
            tx_sample      <= idle_next ? '0 : tx_next;
            underrun_count <= idle_next ? '0 :
                              (near && !on_time && underrun_count != '1) ? underrun_count + U_ONE :
                              underrun_count;
        end
    end
endmodule

// File: tb/tb_audio_frame_scheduler.sv
// tb_audio_frame_scheduler: directed and randomized checks of audio_frame_scheduler against a frame-level model.
module tb_audio_frame_scheduler;
    import audio_sched_pkg::*;
    localparam int MC   = DEF_MCLK_PER_BCLK;
    localparam int BITS = DEF_BITS_PER_SLOT;
    localparam int UMAX = (1 << DEF_UNDERRUN_W) - 1;
    logic input_clk = 1'b0, reset = 1'b1, enable = 1'b1, adc_ack = 1'b0, dsp_out_valid = 1'b0;
    sample_t adc_data = '0, dsp_out_data = '0;
    logic serial_clk, ws, frame_start, adc_req, dsp_in_valid, tx_load, busy;
    logic [4:0] bit_counter;
    logic [7:0] underrun_count;
    sample_t dsp_in_data, tx_sample;
    audio_frame_scheduler dut (
        .input_clk     (input_clk),
        .reset         (reset),
        .enable        (enable),
        .serial_clk    (serial_clk),
        .ws            (ws),
        .bit_counter   (bit_counter),
        .frame_start   (frame_start),
        .adc_req       (adc_req),
        .adc_ack       (adc_ack),
        .adc_data      (adc_data),
        .dsp_in_valid  (dsp_in_valid),
        .dsp_in_data   (dsp_in_data),
        .dsp_out_valid (dsp_out_valid),
        .dsp_out_data  (dsp_out_data),
        .tx_sample     (tx_sample),
        .tx_load       (tx_load),
        .underrun_count(underrun_count),
        .busy          (busy)
    );
    always #5 input_clk = ~input_clk;

    int n_cmp = 0, n_bad = 0, cycle = 0;
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cycle);
            if (n_bad >= 40) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    endtask

    // Frame-level model: a frame runs while enabled; within it the sample is first awaited from the
    // ADC, then from the DSP; the last position is the deadline where the result (or the old word) is loaded.
    int m_pos = 0, m_under = 0;
    bit m_run = 0, m_need_adc = 0, m_need_dsp = 0, m_have = 0, m_fs = 0, m_load = 0, m_din_v = 0;
    sample_t m_res = '0, m_tx = '0, m_din = '0;
    always @(posedge input_clk) begin
        cycle++;
        if (reset) begin
            m_run = 0; m_pos = 0; m_need_adc = 0; m_need_dsp = 0; m_have = 0;
            m_fs = 0; m_load = 0; m_din_v = 0; m_res = '0; m_tx = '0; m_din = '0; m_under = 0;
        end else if (!m_run || m_pos == FRAME_LEN - 1) begin
            m_run = enable; m_pos = 0; m_fs = enable; m_need_adc = enable;
            m_need_dsp = 0; m_have = 0; m_load = 0; m_din_v = 0;
            if (!enable) begin m_tx = '0; m_under = 0; m_din = '0; end
        end else begin
            m_pos++; m_fs = 0; m_load = 0; m_din_v = 0;
            if (m_pos == DEADLINE_POS) begin
                m_load = 1;
                if (m_have) m_tx = m_res;
                else if (m_need_dsp && dsp_out_valid) m_tx = dsp_out_data;
                else if (m_under < UMAX) m_under++;
                m_need_adc = 0; m_need_dsp = 0; m_have = 0;
            end else if (m_need_adc && adc_ack) begin
                m_need_adc = 0; m_need_dsp = 1; m_din = adc_data; m_din_v = 1;
            end else if (m_need_dsp && dsp_out_valid) begin
                m_need_dsp = 0; m_have = 1; m_res = dsp_out_data;
            end
        end
    end

    bit beef_seen = 0;
    always @(negedge input_clk) begin
        chk("serial_clk", int'(serial_clk), int'((m_pos % MC) >= MC / 2));
        chk("bit_counter", int'(bit_counter), (m_pos / MC) % BITS);
        chk("ws", int'(ws), int'(m_pos >= FRAME_LEN / 2));
        chk("frame_start", int'(frame_start), int'(m_fs));
        chk("adc_req", int'(adc_req), int'(m_need_adc));
        chk("dsp_in_valid", int'(dsp_in_valid), int'(m_din_v));
        chk("dsp_in_data", int'(dsp_in_data), int'(m_din));
        chk("tx_load", int'(tx_load), int'(m_load));
        chk("tx_sample", int'(tx_sample), int'(m_tx));
        chk("underrun_count", int'(underrun_count), m_under);
        chk("busy", int'(busy), int'(m_run));
        if (tx_sample == 16'hBEEF) beef_seen = 1;
    end

    // Peripheral responder: drives ADC/DSP replies just after each rising edge.
    int ack_delay = -1, dsp_delay = -1, req_age = 0, dsp_age = 0;
    bit armed = 0, force_beef = 0, noise = 0, rnd = 0;
    sample_t adc_val = '0, dsp_val = '0;
    always @(posedge input_clk) begin
        #2;
        adc_ack = 0; dsp_out_valid = 0;
        adc_data = sample_t'($urandom); dsp_out_data = sample_t'($urandom);
        if (reset) begin
            req_age = 0; armed = 0;
        end else begin
            if (adc_req) begin
                if (req_age == ack_delay) begin
                    adc_ack = 1;
                    adc_data = rnd ? sample_t'($urandom) : adc_val;
                end
                req_age++;
            end else req_age = 0;
            if (dsp_in_valid) begin armed = 1; dsp_age = 0; end
            if (armed) begin
                if (dsp_age == dsp_delay) begin
                    dsp_out_valid = 1;
                    dsp_out_data = rnd ? sample_t'($urandom) : dsp_val;
                    armed = 0;
                end
                dsp_age++;
            end
            if (force_beef && m_pos == DEADLINE_POS) begin dsp_out_valid = 1; dsp_out_data = 16'hBEEF; end
            if (noise && $urandom_range(0, 40) == 0) adc_ack = 1;
            if (noise && $urandom_range(0, 40) == 0) dsp_out_valid = 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge input_clk);
    endtask

    task automatic wait_until(input bit load, input string nm);
        int i;
        for (i = 0; i < 700; i++) begin
            @(negedge input_clk);
            if (load ? tx_load : frame_start) break;
        end
        chk({nm, "_reached"}, int'(i < 700), 1);
    endtask

    initial begin
        int t_fs, n;
        sample_t d;
        cyc(5);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tx_sample", int'(tx_sample), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_adc_req", int'(adc_req), 0);
        reset = 0;
        wait_until(0, "fs0");
        t_fs = cycle;
        wait_until(0, "fs1");
        chk("fs_period", cycle - t_fs, 256);
        chk("fs_rate", MCLK_HZ / (cycle - t_fs), 48000);
        t_fs = cycle;
        chk("sclk_pos0", int'(serial_clk), 0);
        cyc(2);
        chk("sclk_pos2", int'(serial_clk), 1);
        cyc(5);
        chk("bc_pos7", int'(bit_counter), 1);
        chk("sclk_pos7", int'(serial_clk), 1);
        cyc(93);
        enable = 0;
        cyc(28);
        chk("ws_pos128", int'(ws), 1);
        chk("bc_pos128", int'(bit_counter), 0);
        wait_until(1, "load_drop");
        chk("load_pos", cycle - t_fs, 255);
        chk("under_two", int'(underrun_count), 2);
        cyc(1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_sclk", int'(serial_clk), 0);
        chk("idle_load", int'(tx_load), 0);
        ack_delay = 10; dsp_delay = 20; adc_val = 16'h1234; dsp_val = 16'h1235;
        enable = 1;
        wait_until(0, "fs_c");
        n = 0; d = '0;
        for (int i = 0; i < 300 && !tx_load; i++) begin
            @(negedge input_clk);
            if (dsp_in_valid) begin n++; d = dsp_in_data; end
        end
        chk("load_c", int'(tx_load), 1);
        chk("din_pulses", n, 1);
        chk("din_data", int'(d), 16'h1234);
        chk("tx_c", int'(tx_sample), 16'h1235);
        chk("under_c", int'(underrun_count), 0);
        dsp_delay = -1;
        wait_until(1, "load_d");
        chk("tx_d", int'(tx_sample), 16'h1235);
        chk("under_d", int'(underrun_count), 1);
        chk("req_low_d", int'(adc_req), 0);
        cyc(1);
        chk("fs_after_d", int'(frame_start), 1);
        chk("req_after_d", int'(adc_req), 1);
        force_beef = 1;
        wait_until(1, "load_e");
        chk("tx_e", int'(tx_sample), 16'h1235);
        chk("under_e", int'(underrun_count), 2);
        cyc(1);
        force_beef = 0;
        chk("tx_after_e", int'(tx_sample), 16'h1235);
        chk("beef_never", int'(beef_seen), 0);
        rnd = 1; noise = 1;
        for (int i = 0; i < 6500; i++) begin
            @(negedge input_clk);
            if (frame_start) begin
                ack_delay = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 120));
                dsp_delay = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 140));
            end
            reset = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 299) == 0) enable = ~enable;
        end
        reset = 0; enable = 1; noise = 0; rnd = 0; ack_delay = -1; dsp_delay = -1;
        repeat (258) wait_until(1, "load_sat");
        chk("under_sat", int'(underrun_count), 255);
        wait_until(1, "load_sat_hold");
        chk("under_sat_hold", int'(underrun_count), 255);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
